// File: rtl/simon_game_if.sv
// Signal bundle between the game sequencer, the button front-end and the display streamer.
// master = sequencer side, slave = environment (debouncers, streamer, status wrapper).
interface simon_game_if;
  logic        start;
  logic        btn_valid;
  logic [1:0]  btn_colour;
  logic        complete_display;
  logic        rst_display;
  logic        en_display;
  logic [31:0] seq_out;
  logic [3:0]  round_ctr;
  logic [2:0]  state_dbg;
  logic        win;
  logic        lose;

  modport master (
    input  start, btn_valid, btn_colour, complete_display,
    output rst_display, en_display, seq_out, round_ctr, state_dbg, win, lose
  );

  modport slave (
    output start, btn_valid, btn_colour, complete_display,
    input  rst_display, en_display, seq_out, round_ctr, state_dbg, win, lose
  );
endinterface

// File: rtl/simon_game_ctrl.sv
// Colour-memory game sequencer: builds a 16-colour sequence, drives the display
// streamer, checks player presses and tracks rounds through to win or loss.
//
// state   | meaning
// IDLE    | after reset, LFSR free-running, waiting for start
// GEN     | latch LFSR into seq_out, reset streamer, clear round/flags
// SHOW    | streamer playing round_ctr+1 colours
// WAIT_IN | collecting presses, inactivity timer running
// NEXT    | round complete, advance or declare win
// WIN     | win held, LFSR free-running, waiting for start
// LOSE    | lose held, LFSR free-running, waiting for start
module simon_game_ctrl #(
  parameter logic [31:0] LFSR_SEED      = 32'hACE1_2468,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd6_000_000,
  parameter logic [3:0]  MAX_ROUND      = 4'd15
) (
  input  logic            clk,
  input  logic            rst_game,
  simon_game_if.master    gif
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_TC = TW'(TIMEOUT_CYCLES - 24'd1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GEN     = 3'd1,
    SHOW    = 3'd2,
    WAIT_IN = 3'd3,
    NEXT    = 3'd4,
    WIN     = 3'd5,
    LOSE    = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic [31:0]   seq_q, seq_d;
  logic [3:0]    round_q, round_d;
  logic [3:0]    idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          win_q, win_d;
  logic          lose_q, lose_d;
  logic          rst_disp_q, rst_disp_d;
  logic          en_disp_q, en_disp_d;
  logic          fb;
  logic          press_ok;

  always_ff @(posedge clk) begin
    if (rst_game) begin
      state_q    <= IDLE;
      lfsr_q     <= LFSR_SEED;
      seq_q      <= '0;
      round_q    <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
      rst_disp_q <= 1'b1;
      en_disp_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      seq_q      <= seq_d;
      round_q    <= round_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
      rst_disp_q <= rst_disp_d;
      en_disp_q  <= en_disp_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    seq_d    = seq_q;
    round_d  = round_q;
    idx_d    = idx_q;
    timer_d  = timer_q;
    fb       = lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0];
    press_ok = (gif.btn_colour == seq_q[{idx_q, 1'b0} +: 2]);

    case (state_q)
      IDLE, WIN, LOSE: begin
        // The LFSR freezes on the start cycle so seq_out captures that exact value
        if (gif.start) state_d = GEN;
        else           lfsr_d  = {lfsr_q[30:0], fb};
      end
      GEN: begin
        seq_d   = lfsr_q;
        round_d = '0;
        state_d = SHOW;
      end
      SHOW: begin
        if (gif.complete_display) begin
          idx_d   = '0;
          timer_d = '0;
          state_d = WAIT_IN;
        end
      end
      WAIT_IN: begin
        // A press on the terminal-count cycle wins over the timeout
        if (gif.btn_valid) begin
          if (!press_ok) begin
            state_d = LOSE;
          end else if (idx_q == round_q) begin
            state_d = NEXT;
          end else begin
            idx_d   = idx_q + 4'd1;
            timer_d = '0;
          end
        end else if (timer_q == TIMER_TC) begin
          state_d = LOSE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      NEXT: begin
        if (round_q == MAX_ROUND) begin
          state_d = WIN;
        end else begin
          round_d = round_q + 4'd1;
          state_d = SHOW;
        end
      end
      default: state_d = IDLE;
    endcase

    win_d      = (state_d == WIN);
    lose_d     = (state_d == LOSE);
    rst_disp_d = (state_d == GEN);
    // Single-cycle enable: the streamer restarts if en is still high when it finishes
    en_disp_d  = (state_d == SHOW) && (state_q != SHOW);
  end

  assign gif.rst_display = rst_disp_q;
  assign gif.en_display  = en_disp_q;
  assign gif.seq_out     = seq_q;
  assign gif.round_ctr   = round_q;
  assign gif.state_dbg   = state_q;
  assign gif.win         = win_q;
  assign gif.lose        = lose_q;

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Directed-plus-random bench for simon_game_ctrl; the display streamer is played
// by the stimulus itself, and expected values come from a game-level model.
module tb_simon_game_ctrl;

  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic clk = 1'b0;
  logic rst_game;

  simon_game_if gif();

  simon_game_ctrl #(
    .LFSR_SEED      (SEED),
    .TIMEOUT_CYCLES (24'd64),
    .MAX_ROUND      (4'd15)
  ) dut (
    .clk      (clk),
    .rst_game (rst_game),
    .gif      (gif.master)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [31:0] m_lfsr;
  logic [31:0] m_seq;
  logic [31:0] prev_seq;
  int          m_round;

  function automatic logic [31:0] lfsr_adv(input logic [31:0] x, input int n);
    logic [31:0] v;
    v = x;
    for (int i = 0; i < n; i++) v = {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] c);
    gif.btn_valid  = 1'b1;
    gif.btn_colour = c;
    tick();
    gif.btn_valid  = 1'b0;
  endtask

  // start sampled -> GEN -> SHOW with seq_out latched from the LFSR
  task automatic start_game;
    gif.start = 1'b1;
    tick();
    gif.start = 1'b0;
    chk("gen_state", 32'(gif.state_dbg), 32'd1);
    chk("gen_rst_display", 32'(gif.rst_display), 32'd1);
    chk("gen_win_clear", 32'(gif.win), 32'd0);
    chk("gen_lose_clear", 32'(gif.lose), 32'd0);
    tick();
    m_seq   = m_lfsr;
    m_round = 0;
    chk("show_state", 32'(gif.state_dbg), 32'd2);
    chk("show_en", 32'(gif.en_display), 32'd1);
    chk("show_seq", gif.seq_out, m_seq);
    chk("show_round", 32'(gif.round_ctr), 32'd0);
    chk("show_rst_display", 32'(gif.rst_display), 32'd0);
  endtask

  // Streamer stand-in: stray press/start while showing, then complete_display
  task automatic show_wait;
    int d;
    int en_seen;
    d = $urandom_range(1, 5);
    en_seen = 0;
    for (int i = 0; i < d; i++) begin
      gif.btn_valid  = (i == 0);
      gif.btn_colour = 2'($urandom_range(0, 3));
      gif.start      = (i == 0);
      tick();
      gif.btn_valid  = 1'b0;
      gif.start      = 1'b0;
      en_seen += int'(gif.en_display);
    end
    chk("show_en_single", 32'(en_seen), 32'd0);
    chk("show_hold", 32'(gif.state_dbg), 32'd2);
    gif.complete_display = 1'b1;
    tick();
    gif.complete_display = 1'b0;
    chk("wait_in_entry", 32'(gif.state_dbg), 32'd3);
  endtask

  task automatic play_round;
    for (int i = 0; i <= m_round; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      press(m_seq[2*i +: 2]);
      chk("press_state", 32'(gif.state_dbg), (i < m_round) ? 32'd3 : 32'd4);
    end
    tick();
    if (m_round == 15) begin
      chk("win_state", 32'(gif.state_dbg), 32'd5);
      chk("win_flag", 32'(gif.win), 32'd1);
      chk("win_round", 32'(gif.round_ctr), 32'd15);
    end else begin
      m_round++;
      chk("next_show", 32'(gif.state_dbg), 32'd2);
      chk("next_en", 32'(gif.en_display), 32'd1);
      chk("next_round", 32'(gif.round_ctr), 32'(m_round));
      show_wait();
    end
  endtask

  initial begin
    logic [1:0] good_c;
    logic [1:0] bad_c;
    int k;

    gif.start            = 1'b0;
    gif.btn_valid        = 1'b0;
    gif.btn_colour       = 2'd0;
    gif.complete_display = 1'b0;
    rst_game             = 1'b1;
    repeat (3) tick();
    chk("rst_state", 32'(gif.state_dbg), 32'd0);
    chk("rst_display", 32'(gif.rst_display), 32'd1);
    chk("rst_en", 32'(gif.en_display), 32'd0);
    chk("rst_win", 32'(gif.win), 32'd0);
    chk("rst_lose", 32'(gif.lose), 32'd0);
    chk("rst_seq", gif.seq_out, 32'd0);
    chk("rst_round", 32'(gif.round_ctr), 32'd0);

    // Game 1: start on first free cycle, two good rounds, then a wrong press
    rst_game = 1'b0;
    m_lfsr   = SEED;
    start_game();
    show_wait();
    play_round();
    play_round();
    chk("round2_reached", 32'(gif.round_ctr), 32'd2);
    press(m_seq[1:0]);
    chk("r2_first_ok", 32'(gif.state_dbg), 32'd3);
    good_c = m_seq[3:2];
    bad_c  = good_c ^ 2'($urandom_range(1, 3));
    press(bad_c);
    chk("wrong_lose_state", 32'(gif.state_dbg), 32'd6);
    chk("wrong_lose_flag", 32'(gif.lose), 32'd1);
    for (int i = 0; i < 3; i++) begin
      press(2'($urandom_range(0, 3)));
      chk("lose_ignores_btn", 32'(gif.state_dbg), 32'd6);
      chk("lose_held", 32'(gif.lose), 32'd1);
    end
    k = $urandom_range(0, 7);
    repeat (k) tick();
    m_lfsr = lfsr_adv(m_lfsr, 3 + k);

    // Game 2: press on the terminal-count cycle clears the timer; later a timeout
    prev_seq = m_seq;
    start_game();
    show_wait();
    play_round();
    repeat (63) tick();
    chk("tc_still_waiting", 32'(gif.state_dbg), 32'd3);
    press(m_seq[1:0]);
    chk("tc_press_no_loss", 32'(gif.state_dbg), 32'd3);
    chk("tc_press_lose_flag", 32'(gif.lose), 32'd0);
    repeat (63) tick();
    chk("timer_restarted", 32'(gif.state_dbg), 32'd3);
    press(m_seq[3:2]);
    chk("tc_round_done", 32'(gif.state_dbg), 32'd4);
    tick();
    m_round = 2;
    chk("tc_next_round", 32'(gif.round_ctr), 32'd2);
    show_wait();
    repeat (63) tick();
    chk("timeout_edge_minus1", 32'(gif.state_dbg), 32'd3);
    tick();
    chk("timeout_state", 32'(gif.state_dbg), 32'd6);
    chk("timeout_lose", 32'(gif.lose), 32'd1);
    k = $urandom_range(0, 7);
    repeat (k) tick();
    m_lfsr = lfsr_adv(m_lfsr, k);

    // Game 3: play all 16 rounds to a win
    start_game();
    chk("seq_new_game_differs", 32'(gif.seq_out != prev_seq), 32'd1);
    show_wait();
    for (int r = 0; r < 16; r++) play_round();
    repeat (4) tick();
    m_lfsr = lfsr_adv(m_lfsr, 4);
    chk("win_hold_state", 32'(gif.state_dbg), 32'd5);
    chk("win_hold_flag", 32'(gif.win), 32'd1);
    chk("win_round_max", 32'(gif.round_ctr), 32'd15);
    prev_seq = m_seq;
    start_game();
    chk("seq_after_win_differs", 32'(gif.seq_out != prev_seq), 32'd1);

    // Reset in the middle of SHOW
    tick();
    rst_game = 1'b1;
    tick();
    chk("midshow_rst_state", 32'(gif.state_dbg), 32'd0);
    chk("midshow_rst_display", 32'(gif.rst_display), 32'd1);
    chk("midshow_rst_en", 32'(gif.en_display), 32'd0);
    chk("midshow_rst_win", 32'(gif.win), 32'd0);
    chk("midshow_rst_lose", 32'(gif.lose), 32'd0);
    chk("midshow_rst_round", 32'(gif.round_ctr), 32'd0);
    rst_game = 1'b0;
    gif.complete_display = 1'b1;
    tick();
    gif.complete_display = 1'b0;
    chk("post_rst_idle", 32'(gif.state_dbg), 32'd0);
    chk("post_rst_display_low", 32'(gif.rst_display), 32'd0);
    repeat (3) tick();
    chk("post_rst_no_advance", 32'(gif.state_dbg), 32'd0);
    m_lfsr = lfsr_adv(SEED, 4);
    start_game();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
